// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind the UART receiver: AXI4-Stream in/out, sticky error flags and level irq.
// Optional idle timeout is compiled in with `define UART_RX_FIFO_TIMEOUT_EN.
module uart_rx_fifo #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned ADDR_WIDTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 20000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] input_axis_tdata,
    input  logic                  input_axis_tvalid,
    output logic                  input_axis_tready,
    input  logic                  rx_overrun_error,
    input  logic                  rx_frame_error,
    output logic [DATA_WIDTH-1:0] output_axis_tdata,
    output logic                  output_axis_tvalid,
    input  logic                  output_axis_tready,
    input  logic                  flush,
    input  logic                  clear_flags,
    input  logic [ADDR_WIDTH:0]   irq_threshold,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overrun_flag,
    output logic                  frame_flag,
    output logic                  timeout_flag,
    output logic                  irq
);
    localparam int unsigned Depth = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DepthCount = Depth[ADDR_WIDTH:0];

    logic [DATA_WIDTH-1:0] mem [Depth];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  overrun_q, overrun_d, frame_q, frame_d;
    logic                  push, pop;

    assign input_axis_tready  = (count_q != DepthCount);
    assign output_axis_tvalid = (count_q != '0);
    assign output_axis_tdata  = mem[rd_ptr_q];
    assign push               = input_axis_tvalid & input_axis_tready;
    assign pop                = output_axis_tvalid & output_axis_tready;
    assign count              = count_q;
    assign overrun_flag       = overrun_q;
    assign frame_flag         = frame_q;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= input_axis_tdata;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
            unique case ({push, pop})
                2'b10:   count_d = count_q + (ADDR_WIDTH + 1)'(1);
                2'b01:   count_d = count_q - (ADDR_WIDTH + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // A new error pulse wins over a simultaneous clear so no event is lost.
    assign overrun_d = rx_overrun_error | (overrun_q & ~clear_flags);
    assign frame_d   = rx_frame_error | (frame_q & ~clear_flags);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
            frame_q   <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
            frame_q   <= frame_d;
        end
    end

`ifdef UART_RX_FIFO_TIMEOUT_EN
    localparam int unsigned IdleWidth = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [IdleWidth-1:0] idle_q, idle_d;
    logic                 timeout_q, timeout_d;
    logic                 idle_clr, armed;

    assign idle_clr = push | pop | flush | clear_flags;
    assign armed    = (count_q != '0) & ~timeout_q;

    always_comb begin
        idle_d    = idle_q;
        timeout_d = timeout_q;
        if (idle_clr) idle_d = '0;
        else if (armed) idle_d = idle_q + IdleWidth'(1);
        if (pop | flush | clear_flags) begin
            timeout_d = 1'b0;
        end else if (!idle_clr && armed && idle_q == IdleWidth'(TIMEOUT_CYCLES - 1)) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            idle_q    <= idle_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_flag = timeout_q;
`else
    assign timeout_flag = 1'b0;
`endif

    assign irq = ((irq_threshold != '0) && (count_q >= irq_threshold))
               | overrun_q | frame_q | timeout_flag;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: vector table plus fill/wrap, streaming, timeout and reset
// sequences. Timeout expectations follow UART_RX_FIFO_TIMEOUT_EN as compiled.
module tb_uart_rx_fifo;
    localparam int unsigned DW = 8;
    localparam int unsigned AW = 4;
    localparam int unsigned TO = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_valid, in_ready;
    logic          ovr_err, frm_err;
    logic [DW-1:0] out_data;
    logic          out_valid, out_ready;
    logic          flush, clear_flags;
    logic [AW:0]   thr, count;
    logic          ovf, frf, tof, irq;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .input_axis_tdata  (in_data),
        .input_axis_tvalid (in_valid),
        .input_axis_tready (in_ready),
        .rx_overrun_error  (ovr_err),
        .rx_frame_error    (frm_err),
        .output_axis_tdata (out_data),
        .output_axis_tvalid(out_valid),
        .output_axis_tready(out_ready),
        .flush             (flush),
        .clear_flags       (clear_flags),
        .irq_threshold     (thr),
        .count             (count),
        .overrun_flag      (ovf),
        .frame_flag        (frf),
        .timeout_flag      (tof),
        .irq               (irq)
    );

    typedef struct {
        logic          v;
        logic [DW-1:0] d;
        logic          r, fl, clr, ovr, frm;
        logic [AW:0]   th;
        int unsigned   e_cnt;
        logic          e_ov;
        logic [DW-1:0] e_d;
        logic          e_ir, e_irq, e_ovf, e_frf;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic v, input logic [DW-1:0] d, input logic r,
                                input logic fl, input logic clr, input logic ovr,
                                input logic frm, input logic [AW:0] th, input int unsigned ec,
                                input logic eov, input logic [DW-1:0] ed, input logic eir,
                                input logic eirq, input logic eovf, input logic efrf);
        vec_t t;
        t = '{v, d, r, fl, clr, ovr, frm, th, ec, eov, ed, eir, eirq, eovf, efrf};
        vecs.push_back(t);
    endfunction

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_data = '0; out_ready = 0; flush = 0; clear_flags = 0;
        ovr_err = 0; frm_err = 0;
    endtask

    logic [DW-1:0] q[$];

    initial begin
        idle_inputs();
        thr = '0;
        rst = 1'b1;
        #12;
        chk("reset_count", count, 0);
        chk("reset_tvalid", out_valid, 0);
        chk("reset_tready", in_ready, 1);
        chk("reset_flags", {ovf, frf, tof}, 0);
        chk("reset_irq", irq, 0);
        @(negedge clk);
        rst = 1'b0;

        // v d r fl clr ovr frm thr | cnt ov data irdy irq ovf frf
        add(1, 8'h41, 0, 0, 0, 0, 0, 0, 1, 1, 8'h41, 1, 0, 0, 0);
        add(1, 8'h42, 0, 0, 0, 0, 0, 0, 2, 1, 8'h41, 1, 0, 0, 0);
        add(1, 8'h43, 0, 0, 0, 0, 0, 0, 3, 1, 8'h41, 1, 0, 0, 0);
        add(0, 8'h00, 1, 0, 0, 0, 0, 0, 2, 1, 8'h42, 1, 0, 0, 0);
        add(0, 8'h00, 1, 0, 0, 0, 0, 0, 1, 1, 8'h43, 1, 0, 0, 0);
        add(0, 8'h00, 1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 1, 0, 0, 0);
        add(1, 8'h01, 0, 0, 0, 0, 0, 4, 1, 1, 8'h01, 1, 0, 0, 0);
        add(1, 8'h02, 0, 0, 0, 0, 0, 4, 2, 1, 8'h01, 1, 0, 0, 0);
        add(1, 8'h03, 0, 0, 0, 0, 0, 4, 3, 1, 8'h01, 1, 0, 0, 0);
        add(1, 8'h04, 0, 0, 0, 0, 0, 4, 4, 1, 8'h01, 1, 1, 0, 0);
        add(0, 8'h00, 1, 0, 0, 0, 0, 4, 3, 1, 8'h02, 1, 0, 0, 0);
        add(0, 8'h00, 0, 0, 1, 0, 1, 4, 3, 1, 8'h02, 1, 1, 0, 1);
        add(0, 8'h00, 0, 0, 1, 0, 0, 4, 3, 1, 8'h02, 1, 0, 0, 0);
        add(0, 8'h00, 0, 0, 0, 1, 0, 4, 3, 1, 8'h02, 1, 1, 1, 0);
        add(0, 8'h00, 0, 0, 1, 0, 0, 4, 3, 1, 8'h02, 1, 0, 0, 0);
        add(1, 8'h05, 0, 0, 0, 0, 0, 0, 4, 1, 8'h02, 1, 0, 0, 0);
        add(1, 8'h06, 0, 0, 0, 0, 0, 0, 5, 1, 8'h02, 1, 0, 0, 0);
        add(1, 8'h07, 0, 0, 0, 0, 0, 0, 6, 1, 8'h02, 1, 0, 0, 0);
        add(1, 8'h08, 0, 0, 0, 0, 0, 0, 7, 1, 8'h02, 1, 0, 0, 0);
        add(1, 8'h99, 1, 1, 0, 0, 0, 0, 0, 0, 8'h00, 1, 0, 0, 0);
        add(1, 8'h50, 0, 0, 0, 0, 0, 0, 1, 1, 8'h50, 1, 0, 0, 0);
        add(0, 8'h00, 1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 1, 0, 0, 0);

        foreach (vecs[i]) begin
            in_valid = vecs[i].v; in_data = vecs[i].d; out_ready = vecs[i].r;
            flush = vecs[i].fl; clear_flags = vecs[i].clr; ovr_err = vecs[i].ovr;
            frm_err = vecs[i].frm; thr = vecs[i].th;
            tick();
            chk($sformatf("vec%0d_count", i), count, vecs[i].e_cnt);
            chk($sformatf("vec%0d_tvalid", i), out_valid, vecs[i].e_ov);
            if (vecs[i].e_ov) chk($sformatf("vec%0d_tdata", i), out_data, vecs[i].e_d);
            chk($sformatf("vec%0d_tready", i), in_ready, vecs[i].e_ir);
            chk($sformatf("vec%0d_irq", i), irq, vecs[i].e_irq);
            chk($sformatf("vec%0d_flags", i), {ovf, frf}, {vecs[i].e_ovf, vecs[i].e_frf});
        end
        idle_inputs();
        thr = '0;

        // Fill to depth with tvalid held, then one pop lets the held byte in.
        in_valid = 1;
        for (int i = 0; i < 16; i++) begin
            in_data = 8'(i);
            tick();
            chk($sformatf("fill%0d_count", i), count, i + 1);
            chk($sformatf("fill%0d_tready", i), in_ready, (i < 15) ? 1 : 0);
        end
        in_data = 8'h10;
        tick();
        chk("full_hold_count", count, 16);
        chk("full_head", out_data, 8'h00);
        out_ready = 1;
        tick();
        chk("full_pop_count", count, 15);
        chk("full_pop_tready", in_ready, 1);
        out_ready = 0;
        tick();
        chk("refill_count", count, 16);
        chk("refill_tready", in_ready, 0);
        in_valid = 0;
        for (int k = 1; k <= 16; k++) begin
            chk($sformatf("drain%0d_data", k), out_data, k);
            out_ready = 1;
            tick();
        end
        out_ready = 0;
        chk("drain_count", count, 0);
        chk("drain_tvalid", out_valid, 0);

        // Five-deep streaming across pointer wrap.
        in_valid = 1;
        for (int k = 0; k < 5; k++) begin
            in_data = 8'(8'h80 + k);
            q.push_back(in_data);
            tick();
        end
        out_ready = 1;
        for (int k = 0; k < 20; k++) begin
            in_data = 8'(8'h85 + k);
            chk($sformatf("stream%0d_head", k), out_data, q[0]);
            tick();
            void'(q.pop_front());
            q.push_back(in_data);
            chk($sformatf("stream%0d_count", k), count, 5);
        end
        in_valid = 0;
        while (q.size() != 0) begin
            chk("stream_drain_data", out_data, q.pop_front());
            tick();
        end
        out_ready = 0;
        chk("stream_end_count", count, 0);

        // Idle timeout after a single push.
        in_valid = 1; in_data = 8'h77;
        tick();
        in_valid = 0;
        for (int c = 1; c <= 12; c++) begin
            tick();
`ifdef UART_RX_FIFO_TIMEOUT_EN
            chk($sformatf("timeout_c%0d", c), tof, (c >= 10) ? 1 : 0);
            chk($sformatf("timeout_irq_c%0d", c), irq, (c >= 10) ? 1 : 0);
`else
            chk($sformatf("timeout_off_c%0d", c), {tof, irq}, 0);
`endif
        end
        out_ready = 1;
        tick();
        out_ready = 0;
        chk("timeout_pop_flag", tof, 0);
        chk("timeout_pop_irq", irq, 0);
        chk("timeout_pop_count", count, 0);

        // Asynchronous reset mid-operation.
        in_valid = 1; in_data = 8'h33; ovr_err = 1;
        tick();
        tick();
        in_valid = 0; ovr_err = 0;
        chk("pre_rst_count", count, 2);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_count", count, 0);
        chk("async_rst_tvalid", out_valid, 0);
        chk("async_rst_flags", {ovf, frf, tof, irq}, 0);
        @(negedge clk);
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive buffer placed directly downstream of the UART receiver. It accepts bytes on an AXI4-Stream slave port and stores them in a synchronous FIFO. It presents them to the CPU-side register bridge on an AXI4-Stream master port. It also latches the receiver's overrun/frame error pulses into sticky flags and generates a level interrupt from fill threshold, errors and an optional idle timeout.

## Interface
- DATA_WIDTH, 8: byte width; must match receiver.
- ADDR_WIDTH, 4: FIFO depth = 2**ADDR_WIDTH entries (16).
- TIMEOUT_CYCLES, 20000: idle clocks before timeout flag (used only with UART_RX_FIFO_TIMEOUT_EN); must be ≥ 2.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- input_axis_tdata  in  DATA_WIDTH  byte from receiver.
- input_axis_tvalid  in  1  byte valid.
- input_axis_tready  out  1  = !full.
- rx_overrun_error  in  1  one-cycle pulse from receiver.
- rx_frame_error  in  1  one-cycle pulse from receiver.
- output_axis_tdata  out  DATA_WIDTH  head-of-FIFO byte.
- output_axis_tvalid  out  1  = !empty.
- output_axis_tready  in  1  consumer pop request.
- flush  in  1  synchronous FIFO clear.
- clear_flags  in  1  clears sticky flags.
- irq_threshold  in  ADDR_WIDTH+1  fill level for irq; 0 disables threshold term.
- count  out  ADDR_WIDTH+1  current occupancy, 0..2**ADDR_WIDTH.
- overrun_flag, frame_flag, timeout_flag  out  1 each  sticky status.
- irq  out  1  level interrupt.

## Operation
- Storage: DATA_WIDTH × 2**ADDR_WIDTH array, write/read pointers ADDR_WIDTH bits, wrap naturally modulo depth; count register ADDR_WIDTH+1 bits.
- Push = input_axis_tvalid & input_axis_tready; writes mem[wr_ptr], wr_ptr+1.
- Pop = output_axis_tvalid & output_axis_tready; rd_ptr+1.
- output_axis_tdata = mem[rd_ptr] (first-word fall-through, combinational read of registered array).
- Push and pop same cycle: both pointers advance, count unchanged. Legal when 0 < count < depth. When full, tready=0 so no push even if popping; when empty, no pop.
- Push with count == depth is impossible by construction.
- flush: pointers and count → 0 next edge; concurrent push/pop ignored (flush wins).
- Sticky flags: overrun_flag set by rx_overrun_error, frame_flag by rx_frame_error. clear_flags clears both (and timeout_flag). Set dominates clear in the same cycle.
- Receiver tvalid held while tready=0 is lost data reported by the receiver's own overrun pulse. This block does not count drops.
- irq = (irq_threshold != 0 && count >= irq_threshold) | overrun_flag | frame_flag | timeout_flag; combinational from registers.

## Timing
- Reset values: count 0, pointers 0, input_axis_tready 1, output_axis_tvalid 0, all flags 0, irq 0; output_axis_tdata = mem[0] (undefined content, don't-care while tvalid=0).
- Latency: byte pushed at edge N → output_axis_tvalid=1 and count updated after edge N.
- Full at count == 2**ADDR_WIDTH: tready drops after the filling edge; rises after the first pop edge.
- Error pulse at edge N → flag high after edge N; irq same cycle as flag.
- Reset mid-operation: all state cleared immediately (asynchronous); contents abandoned.

## Configuration
- UART_RX_FIFO_TIMEOUT_EN defined:
  - An idle counter clears on push, pop, flush or clear_flags.
  - It increments each cycle while count != 0 and timeout_flag = 0.
  - On reaching TIMEOUT_CYCLES-1 it sets timeout_flag at the next edge.
  - timeout_flag clears on pop, flush or clear_flags.
  - It is re-armed only by subsequent idle time with count != 0.
- Not defined: no counter logic; timeout_flag tied 0; TIMEOUT_CYCLES ignored.

## Test plan
- Push 0x41,0x42,0x43 with output_axis_tready=0 → count=3, tdata=0x41; pop three → 0x41,0x42,0x43 in order, count=0, tvalid=0.
- Push 17 bytes 0x00..0x10 at depth 16 with tvalid held → tready=0 after 16th push, count=16; one pop returns 0x00, then 0x10 accepted, count=16; pointers wrapped correctly.
- Continuous push+pop every cycle at count=5 → count stays 5, data order preserved across pointer wrap.
- irq_threshold=4: push 3 → irq=0; 4th push → irq=1; one pop → irq=0. Pulse rx_frame_error with clear_flags same cycle → frame_flag=1; clear_flags alone next → 0.
- flush asserted while count=7 with concurrent push → count=0, tvalid=0, tready=1, pushed byte discarded.
- (UART_RX_FIFO_TIMEOUT_EN, TIMEOUT_CYCLES=10) push one byte then idle → timeout_flag and irq rise 10 cycles after push edge; pop → flag clears; with macro undefined flag stays 0.
